pipe_hazard_ctrl: RTL and testbench

- Stall/bubble sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB); sits beside the pipeline registers.
- Keeps its own shadow copy of the destination-select/load/store fields for EX and MEM, using the 32-bit one-hot register-select format.
- Detects load-use and ID-stage-branch hazards and freezes the pipe on data-memory wait.
- Drives hold/bubble controls to PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble sequencer for the 5-stage pipeline
//
// Tracks shadow copies of the EX and MEM destination/load/store fields
// (32-bit one-hot register selects) and drives hold/bubble controls to
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Priority: mem wait > load-use > branch.
//
// Ports:
//   clk, reset        pipeline clock, asynchronous active-high reset
//   id_aselect/bselect one-hot rs/rt selects of the ID instruction
//   id_uses_b         ID instruction reads rt
//   id_dselect        one-hot destination of the ID instruction (0 = none)
//   id_load/store/branch  ID instruction class
//   mem_ready         data memory completes the MEM access this cycle
//   pc_hold, ifid_hold, idex_bubble, exmem_hold, memwb_bubble  pipeline controls
//   state             registered code of last winning condition (RUN/LU/BR/MEM_WAIT)
//   mem_timeout       sticky, set when a memory wait hits MAX_WAIT
//   lu_cnt, br_cnt, wait_cnt  saturating performance counters
//
// Optional: define HAZ_PERF_EN to build the performance counters; otherwise
// the counter ports are tied to 0.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_aselect,
    input  logic [31:0]      id_bselect,
    input  logic             id_uses_b,
    input  logic [31:0]      id_dselect,
    input  logic             id_load,
    input  logic             id_store,
    input  logic             id_branch,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] wait_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, BR_STALL = 2'd2, MEM_WAIT = 2'd3} state_t;
    localparam int WW = $clog2(MAX_WAIT + 1);
    state_t cur, nxt;
    logic [31:0] src, ex_dsel, mem_dsel;
    logic ex_load, ex_store, mem_load, mem_store;
    logic [WW-1:0] wait_ctr;
    logic timeout_release, mw, lu, br, ex_hit;
    // r0 is hardwired zero, so it can never carry a dependency
    assign src = (id_aselect | (id_uses_b ? id_bselect : 32'h0)) & ~32'h1;
    assign ex_hit = |(ex_dsel & src);
    assign timeout_release = wait_ctr == WW'(MAX_WAIT);
    assign mw = (mem_load | mem_store) & ~mem_ready & ~timeout_release;
    assign lu = ex_load & ex_hit;
    // branches compare in ID, so a load result is not usable until it leaves MEM
    assign br = id_branch & (ex_hit | (mem_load & |(mem_dsel & src)));
    assign state = cur;
    always_comb begin
        nxt = mw ? MEM_WAIT : lu ? LU_STALL : br ? BR_STALL : RUN;
        pc_hold = nxt != RUN;
        ifid_hold = nxt != RUN;
        idex_bubble = nxt == LU_STALL || nxt == BR_STALL;
        exmem_hold = mw;
        memwb_bubble = mw;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= RUN;
        else cur <= nxt;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_dsel <= '0;
            ex_load <= 1'b0;
            ex_store <= 1'b0;
            mem_dsel <= '0;
            mem_load <= 1'b0;
            mem_store <= 1'b0;
        end else if (!mw) begin
            mem_dsel <= ex_dsel;
            mem_load <= ex_load;
            mem_store <= ex_store;
            ex_dsel <= idex_bubble ? 32'h0 : id_dselect;
            ex_load <= idex_bubble ? 1'b0 : id_load;
            ex_store <= idex_bubble ? 1'b0 : id_store;
        end
    end
    // counter reaching MAX_WAIT forces one release cycle, which also clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_ctr <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wait_ctr <= mw ? wait_ctr + WW'(1) : '0;
            mem_timeout <= mem_timeout | timeout_release;
        end
    end
`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_cnt <= '0;
            br_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (nxt == LU_STALL && lu_cnt != '1) lu_cnt <= lu_cnt + CNT_W'(1);
            if (nxt == BR_STALL && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
            if (nxt == MEM_WAIT && wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign lu_cnt = '0;
    assign br_cnt = '0;
    assign wait_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: random and directed checks of pipe_hazard_ctrl against an instruction-level model
module tb_pipe_hazard_ctrl;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W = 16;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] id_aselect = '0, id_bselect = '0, id_dselect = '0;
    logic id_uses_b = 1'b0, id_load = 1'b0, id_store = 1'b0, id_branch = 1'b0, mem_ready = 1'b1;
    logic pc_hold, ifid_hold, idex_bubble, exmem_hold, memwb_bubble, mem_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] lu_cnt, br_cnt, wait_cnt;
    always #5 clk = ~clk;
    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_aselect(id_aselect), .id_bselect(id_bselect), .id_uses_b(id_uses_b),
        .id_dselect(id_dselect), .id_load(id_load), .id_store(id_store), .id_branch(id_branch),
        .mem_ready(mem_ready),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble),
        .state(state), .mem_timeout(mem_timeout),
        .lu_cnt(lu_cnt), .br_cnt(br_cnt), .wait_cnt(wait_cnt)
    );
    int n_chk = 0, n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // instruction-level model: each slot is an instruction described by register numbers
    typedef struct {bit wr; int rd; bit ld; bit st;} slot_t;
    slot_t m_ex, m_mem, id_slot;
    int rs, rt, m_state, m_wait, m_lu, m_br, m_mw;
    bit ub, brn, m_to, stalled;
    function automatic bit hits(slot_t s);
        return s.wr && s.rd != 0 && (s.rd == rs || (ub && s.rd == rt));
    endfunction
    // kinds: 0 nop, 1 add (rs,rt), 2 lw (rs), 3 sw (rs,rt), 4 beq (rs,rt), 5 addi (rs)
    task automatic drive(input int k, input int a, input int b, input int d);
        rs = a; rt = b;
        ub = k == 1 || k == 3 || k == 4;
        brn = k == 4;
        id_slot.wr = k == 1 || k == 2 || k == 5;
        id_slot.rd = d;
        id_slot.ld = k == 2;
        id_slot.st = k == 3;
        id_aselect = 32'h1 << a;
        id_bselect = 32'h1 << b;
        id_uses_b = ub;
        id_dselect = id_slot.wr ? 32'h1 << d : 32'h0;
        id_load = id_slot.ld;
        id_store = id_slot.st;
        id_branch = brn;
    endtask
    task automatic step(input int k, input int a, input int b, input int d, input bit rdy);
        bit tr, mw, lu, br;
        @(negedge clk);
        drive(k, a, b, d);
        mem_ready = rdy;
        #1;
        tr = m_wait == MAX_WAIT;
        mw = (m_mem.ld || m_mem.st) && !rdy && !tr;
        lu = m_ex.ld && hits(m_ex);
        br = brn && (hits(m_ex) || (m_mem.ld && hits(m_mem)));
        stalled = mw || lu || br;
        check("pc_hold", 32'(pc_hold), 32'(stalled));
        check("ifid_hold", 32'(ifid_hold), 32'(stalled));
        check("idex_bubble", 32'(idex_bubble), 32'(!mw && (lu || br)));
        check("exmem_hold", 32'(exmem_hold), 32'(mw));
        check("memwb_bubble", 32'(memwb_bubble), 32'(mw));
        check("state", 32'(state), 32'(m_state));
        check("mem_timeout", 32'(mem_timeout), 32'(m_to));
        check("lu_cnt", 32'(lu_cnt), 32'(m_lu));
        check("br_cnt", 32'(br_cnt), 32'(m_br));
        check("wait_cnt", 32'(wait_cnt), 32'(m_mw));
        @(posedge clk);
        m_state = mw ? 3 : lu ? 1 : br ? 2 : 0;
        m_to = m_to || tr;
        m_wait = mw ? m_wait + 1 : 0;
`ifdef HAZ_PERF_EN
        m_lu += int'(m_state == 1);
        m_br += int'(m_state == 2);
        m_mw += int'(m_state == 3);
`endif
        if (!mw) begin
            m_mem = m_ex;
            m_ex = (lu || br) ? '{0, 0, 0, 0} : id_slot;
        end
    endtask
    task automatic model_reset();
        m_ex = '{0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0};
        m_state = 0; m_wait = 0; m_lu = 0; m_br = 0; m_mw = 0; m_to = 0;
    endtask
    task automatic flush();
        repeat (3) step(0, 0, 0, 0, 1);
    endtask
    initial begin
        int k, a, b, d;
        model_reset();
        drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("rst_pc_hold", 32'(pc_hold), 32'h0);
        check("rst_state", 32'(state), 32'h0);
        check("rst_timeout", 32'(mem_timeout), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        // load-use: lw r2 then add r4,r2,r3
        flush();
        step(2, 1, 0, 2, 1);
        step(1, 2, 3, 4, 1);
        step(1, 2, 3, 4, 1);
        step(0, 0, 0, 0, 1);
        // branch after ALU producer: one stall
        flush();
        step(1, 1, 1, 3, 1);
        step(4, 3, 4, 0, 1);
        step(4, 3, 4, 0, 1);
        // branch after load producer: two stalls
        flush();
        step(2, 1, 0, 3, 1);
        repeat (3) step(4, 3, 4, 0, 1);
        // r0 producer/consumer: never a hazard
        flush();
        step(2, 1, 0, 0, 1);
        step(1, 0, 0, 5, 1);
        step(4, 0, 0, 0, 1);
        // store waiting three cycles in MEM
        flush();
        step(3, 1, 2, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("no_timeout_yet", 32'(mem_timeout), 32'h0);
        // random traffic over a small register window to provoke hazards
        flush();
        k = 0; a = 0; b = 0; d = 0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                k = $urandom_range(0, 5);
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 3);
                d = $urandom_range(0, 3);
            end
            step(k, a, b, d, $urandom_range(0, 3) != 0);
        end
        // memory never ready: forced release after MAX_WAIT cycles
        flush();
        step(3, 1, 2, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (MAX_WAIT + 2) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("timeout_sticky", 32'(mem_timeout), 32'h1);
        // reset in the middle of a load-use stall
        flush();
        step(2, 1, 0, 2, 1);
        @(negedge clk);
        drive(1, 2, 3, 4);
        mem_ready = 1'b1;
        #1;
        check("pre_rst_stall", 32'(pc_hold), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_pc_hold2", 32'(pc_hold), 32'h0);
        check("rst_ifid_hold2", 32'(ifid_hold), 32'h0);
        check("rst_idex_bubble2", 32'(idex_bubble), 32'h0);
        check("rst_state2", 32'(state), 32'h0);
        check("rst_timeout2", 32'(mem_timeout), 32'h0);
        check("rst_lu_cnt", 32'(lu_cnt), 32'h0);
        model_reset();
        drive(0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(2, 1, 0, 2, 1);
        step(1, 2, 3, 4, 1);
        step(1, 2, 3, 4, 1);
`ifdef HAZ_PERF_EN
        check("lu_cnt_one", 32'(lu_cnt), 32'h1);
`else
        check("lu_cnt_off", 32'(lu_cnt), 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
